// File: rtl/ocd_lvl_dec_if.sv
// ocd_lvl_dec_if: PWM line in, decoded level/valid/stuck out
interface ocd_lvl_dec_if #(parameter int PAR_MAX_VAL = 100);
   localparam int LW = $clog2(PAR_MAX_VAL + 1);
   logic          pwm_in;
   logic [LW-1:0] lvl;
   logic          valid;
   logic          stuck;
   modport master (output pwm_in, input lvl, valid, stuck);
   modport slave  (input pwm_in, output lvl, valid, stuck);
endinterface

// File: rtl/ocd_lvl_dec.sv
// ocd_lvl_dec: one-period high-time count of a PWM line, divided back to a level
module ocd_lvl_dec #(
   parameter int CLK_MHZ     = 100,
   parameter int FREQ_KHZ    = 100,
   parameter int PAR_MAX_VAL = 100
) (
   input logic           clk,
   input logic           rst,
   ocd_lvl_dec_if.slave  bus
);
   localparam int CNT_MAX = 1000 * CLK_MHZ / FREQ_KHZ;
   localparam int K       = CNT_MAX / PAR_MAX_VAL;
   localparam int WW      = $clog2(CNT_MAX);
   localparam int HW      = $clog2(CNT_MAX + 1);
   localparam int LW      = $clog2(PAR_MAX_VAL + 1);
   localparam logic [HW-1:0] KV   = HW'(K);
   localparam logic [HW-1:0] PMAX = HW'(PAR_MAX_VAL);
   typedef enum logic {IDLE, DIV} state_t;
   state_t        state_q, state_d;
   logic          sync1_q, sync1_d, s_q, s_d, sp_q, sp_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d, rem_q, rem_d, q_q, q_d;
   logic          ef_q, ef_d, edl_q, edl_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic          valid_q, valid_d, stuck_q, stuck_d;
   logic          edge_w, win_end;
   always_comb begin
      sync1_d = bus.pwm_in;
      s_d     = sync1_q;
      sp_d    = s_q;
      edge_w  = s_q ^ sp_q;
      win_end = wcnt_q == '0;
      wcnt_d  = win_end ? WW'(CNT_MAX - 1) : wcnt_q - WW'(1);
      hcnt_d  = win_end ? '0 : hcnt_q + HW'(s_q);
      ef_d    = win_end ? 1'b0 : ef_q | edge_w;
      state_d = state_q;
      rem_d   = rem_q;
      q_d     = q_q;
      edl_d   = edl_q;
      lvl_d   = lvl_q;
      stuck_d = stuck_q;
      valid_d = 1'b0;
      if (state_q == IDLE) begin
         if (win_end) begin
            // the closing cycle's sample belongs to the window being latched
            rem_d   = hcnt_q + HW'(s_q);
            q_d     = '0;
            edl_d   = ef_q | edge_w;
            state_d = DIV;
         end
      end else if (rem_q >= KV) begin
         rem_d = rem_q - KV;
         q_d   = q_q + HW'(1);
      end else begin
         lvl_d   = (q_q > PMAX) ? LW'(PAR_MAX_VAL) : q_q[LW-1:0];
         stuck_d = !edl_q;
         valid_d = 1'b1;
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         sp_q    <= 1'b0;
         wcnt_q  <= WW'(CNT_MAX - 1);
         hcnt_q  <= '0;
         ef_q    <= 1'b0;
         state_q <= IDLE;
         rem_q   <= '0;
         q_q     <= '0;
         edl_q   <= 1'b0;
         lvl_q   <= '0;
         stuck_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         s_q     <= s_d;
         sp_q    <= sp_d;
         wcnt_q  <= wcnt_d;
         hcnt_q  <= hcnt_d;
         ef_q    <= ef_d;
         state_q <= state_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         edl_q   <= edl_d;
         lvl_q   <= lvl_d;
         stuck_q <= stuck_d;
         valid_q <= valid_d;
      end
   end
   assign bus.lvl   = lvl_q;
   assign bus.valid = valid_q;
   assign bus.stuck = stuck_q;
endmodule
